// File: rtl/fc_layer_nlane_requant.sv
// fc_layer_nlane_requant: fully-connected int8 layer over packed BRAM words.
// Each neuron streams WORDS activation/weight words and multiplies LANES
// uint8 x int8 pairs per word. It accumulates into a signed ACC_WIDTH
// register, adds the neuron bias, requantizes with an arithmetic right
// shift and a clamp, and writes one sign-extended result word per neuron.
// Optional feature macro: FC_LAYER_RELU_EN narrows the clamp to [0,127].
module fc_layer_nlane_requant #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 12,
  parameter int LANES       = DATA_WIDTH / 8,
  parameter int INPUT_SIZE  = 16,
  parameter int OUTPUT_SIZE = 10,
  parameter int SHIFT       = 0,
  parameter int ACC_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_run,
  output logic                  ce_input,
  output logic                  we_input,
  output logic [ADDR_WIDTH-1:0] addr_input,
  output logic [DATA_WIDTH-1:0] din_input,
  input  logic [DATA_WIDTH-1:0] qout_input,
  output logic                  ce_weight,
  output logic                  we_weight,
  output logic [ADDR_WIDTH-1:0] addr_weight,
  output logic [DATA_WIDTH-1:0] din_weight,
  input  logic [DATA_WIDTH-1:0] qout_weight,
  output logic                  ce_bias,
  output logic                  we_bias,
  output logic [ADDR_WIDTH-1:0] addr_bias,
  output logic [DATA_WIDTH-1:0] din_bias,
  input  logic [DATA_WIDTH-1:0] qout_bias,
  output logic                  ce_output,
  output logic                  we_output,
  output logic [ADDR_WIDTH-1:0] addr_output,
  output logic [DATA_WIDTH-1:0] din_output,
  input  logic [DATA_WIDTH-1:0] qout_output,
  output logic                  o_busy,
  output logic                  layer_done
);

  localparam int WORDS = INPUT_SIZE / LANES;
  localparam logic [ADDR_WIDTH-1:0] LAST_K = ADDR_WIDTH'(WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_N = ADDR_WIDTH'(OUTPUT_SIZE - 1);
  localparam logic signed [ACC_WIDTH-1:0] Q_MAX = ACC_WIDTH'(32'sd127);
`ifdef FC_LAYER_RELU_EN
  localparam logic signed [ACC_WIDTH-1:0] Q_MIN = ACC_WIDTH'(32'sd0);
`else
  localparam logic signed [ACC_WIDTH-1:0] Q_MIN = ACC_WIDTH'(-32'sd128);
`endif

  if (INPUT_SIZE % LANES != 0) begin : g_bad_input_size
    $error("INPUT_SIZE must be a multiple of LANES");
  end
  if (DATA_WIDTH % 8 != 0) begin : g_bad_data_width
    $error("DATA_WIDTH must be a multiple of 8");
  end
  if (longint'(OUTPUT_SIZE) * longint'(WORDS) > (64'sd1 << ADDR_WIDTH)) begin : g_bad_addr_width
    $error("OUTPUT_SIZE*WORDS does not fit in ADDR_WIDTH");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DRAIN = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                       state_r;
  logic [ADDR_WIDTH-1:0]        k_r;
  logic [ADDR_WIDTH-1:0]        n_r;
  logic                         drain_r;
  logic                         rd_vld_r;
  logic                         sum_vld_r;
  logic                         bias_vld_r;
  logic signed [ACC_WIDTH-1:0]  sum_r;
  logic signed [ACC_WIDTH-1:0]  acc_r;
  logic signed [ACC_WIDTH-1:0]  bias_r;

  logic signed [8:0]            act_s [LANES];
  logic signed [7:0]            wt_s  [LANES];
  logic signed [16:0]           prod_s [LANES];
  logic signed [ACC_WIDTH-1:0]  lane_sum_s;
  logic signed [ACC_WIDTH-1:0]  acc_next_s;
  logic signed [ACC_WIDTH-1:0]  biased_s;
  logic signed [ACC_WIDTH-1:0]  shifted_s;
  logic signed [7:0]            q8_s;
  logic [DATA_WIDTH-1:0]        result_s;
  logic                         unused_s;

  // Read ports never write; the result port only writes.
  assign we_input   = 1'b0;
  assign we_weight  = 1'b0;
  assign we_bias    = 1'b0;
  assign din_input  = {DATA_WIDTH{1'b0}};
  assign din_weight = {DATA_WIDTH{1'b0}};
  assign din_bias   = {DATA_WIDTH{1'b0}};
  assign we_output  = 1'b1;
  assign unused_s   = ^qout_output;

  // Lane products: lane 0 is the most significant byte, activation unsigned, weight signed.
  always_comb begin
    lane_sum_s = {ACC_WIDTH{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      act_s[i]   = signed'({1'b0, qout_input[DATA_WIDTH-1-8*i -: 8]});
      wt_s[i]    = signed'(qout_weight[DATA_WIDTH-1-8*i -: 8]);
      prod_s[i]  = 17'(act_s[i]) * 17'(wt_s[i]);
      lane_sum_s = lane_sum_s + ACC_WIDTH'(prod_s[i]);
    end
  end

  // Requantize the accumulator value that lands on the edge entering WRITE.
  always_comb begin
    if (sum_vld_r) begin
      acc_next_s = acc_r + sum_r;
    end else begin
      acc_next_s = acc_r;
    end
    biased_s  = acc_next_s + bias_r;
    shifted_s = biased_s >>> SHIFT;
    if (shifted_s > Q_MAX) begin
      q8_s = Q_MAX[7:0];
    end else if (shifted_s < Q_MIN) begin
      q8_s = Q_MIN[7:0];
    end else begin
      q8_s = shifted_s[7:0];
    end
    result_s = {{(DATA_WIDTH-8){q8_s[7]}}, q8_s};
  end

  // Two-stage MAC pipeline plus bias capture; acc clears on the WRITE edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_vld_r   <= 1'b0;
      sum_vld_r  <= 1'b0;
      bias_vld_r <= 1'b0;
      sum_r      <= {ACC_WIDTH{1'b0}};
      acc_r      <= {ACC_WIDTH{1'b0}};
      bias_r     <= {ACC_WIDTH{1'b0}};
    end else begin
      rd_vld_r   <= ce_input;
      sum_vld_r  <= rd_vld_r;
      bias_vld_r <= ce_bias;
      if (rd_vld_r) begin
        sum_r <= lane_sum_s;
      end
      if (bias_vld_r) begin
        bias_r <= ACC_WIDTH'(signed'(qout_bias));
      end
      if (state_r == S_WRITE) begin
        acc_r <= {ACC_WIDTH{1'b0}};
      end else begin
        acc_r <= acc_next_s;
      end
    end
  end

  // Layer sequencer with registered BRAM controls and status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= S_IDLE;
      k_r         <= {ADDR_WIDTH{1'b0}};
      n_r         <= {ADDR_WIDTH{1'b0}};
      drain_r     <= 1'b0;
      ce_input    <= 1'b0;
      addr_input  <= {ADDR_WIDTH{1'b0}};
      ce_weight   <= 1'b0;
      addr_weight <= {ADDR_WIDTH{1'b0}};
      ce_bias     <= 1'b0;
      addr_bias   <= {ADDR_WIDTH{1'b0}};
      ce_output   <= 1'b0;
      addr_output <= {ADDR_WIDTH{1'b0}};
      din_output  <= {DATA_WIDTH{1'b0}};
      o_busy      <= 1'b0;
      layer_done  <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (i_run) begin
            state_r     <= S_LOAD;
            k_r         <= {ADDR_WIDTH{1'b0}};
            n_r         <= {ADDR_WIDTH{1'b0}};
            ce_input    <= 1'b1;
            addr_input  <= {ADDR_WIDTH{1'b0}};
            ce_weight   <= 1'b1;
            addr_weight <= {ADDR_WIDTH{1'b0}};
            ce_bias     <= 1'b1;
            addr_bias   <= {ADDR_WIDTH{1'b0}};
            o_busy      <= 1'b1;
          end
        end
        S_LOAD: begin
          ce_bias <= 1'b0;
          if (k_r == LAST_K) begin
            state_r   <= S_DRAIN;
            drain_r   <= 1'b0;
            ce_input  <= 1'b0;
            ce_weight <= 1'b0;
          end else begin
            k_r         <= k_r + ADDR_WIDTH'(1);
            addr_input  <= k_r + ADDR_WIDTH'(1);
            addr_weight <= addr_weight + ADDR_WIDTH'(1);
          end
        end
        S_DRAIN: begin
          if (drain_r) begin
            state_r     <= S_WRITE;
            ce_output   <= 1'b1;
            addr_output <= n_r;
            din_output  <= result_s;
          end else begin
            drain_r <= 1'b1;
          end
        end
        S_WRITE: begin
          ce_output <= 1'b0;
          if (n_r == LAST_N) begin
            state_r    <= S_DONE;
            layer_done <= 1'b1;
            o_busy     <= 1'b0;
          end else begin
            state_r     <= S_LOAD;
            n_r         <= n_r + ADDR_WIDTH'(1);
            k_r         <= {ADDR_WIDTH{1'b0}};
            ce_input    <= 1'b1;
            addr_input  <= {ADDR_WIDTH{1'b0}};
            ce_weight   <= 1'b1;
            addr_weight <= addr_weight + ADDR_WIDTH'(1);
            ce_bias     <= 1'b1;
            addr_bias   <= n_r + ADDR_WIDTH'(1);
          end
        end
        S_DONE: begin
          layer_done <= 1'b0;
          state_r    <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fc_layer_nlane_requant.sv
// Directed bench for fc_layer_nlane_requant: LANES=4, INPUT_SIZE=8 (WORDS=2),
// OUTPUT_SIZE=2. Instance a uses SHIFT=0, instance b uses SHIFT=2. Both share
// the behavioural BRAM contents, and each has its own 1-cycle read ports.
module tb_fc_layer_nlane_requant;
  localparam int DW = 32;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic reset;
  logic run_a, run_b;
  always #5 clk = ~clk;

  logic [DW-1:0] act_mem [2];
  logic [DW-1:0] wt_mem [4];
  logic [DW-1:0] bias_mem [2];

  logic          ce_input_a, we_input_a, ce_weight_a, we_weight_a, ce_bias_a, we_bias_a;
  logic          ce_output_a, we_output_a, o_busy_a, layer_done_a;
  logic [AW-1:0] addr_input_a, addr_weight_a, addr_bias_a, addr_output_a;
  logic [DW-1:0] din_input_a, din_weight_a, din_bias_a, din_output_a;
  logic [DW-1:0] qin_a, qw_a, qb_a;
  logic          ce_input_b, we_input_b, ce_weight_b, we_weight_b, ce_bias_b, we_bias_b;
  logic          ce_output_b, we_output_b, o_busy_b, layer_done_b;
  logic [AW-1:0] addr_input_b, addr_weight_b, addr_bias_b, addr_output_b;
  logic [DW-1:0] din_input_b, din_weight_b, din_bias_b, din_output_b;
  logic [DW-1:0] qin_b, qw_b, qb_b;
  logic [DW-1:0] qout_zero = '0;

  fc_layer_nlane_requant #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LANES(4), .INPUT_SIZE(8),
                           .OUTPUT_SIZE(2), .SHIFT(0), .ACC_WIDTH(32)) dut_a (
    .clk(clk), .reset(reset), .i_run(run_a),
    .ce_input(ce_input_a), .we_input(we_input_a), .addr_input(addr_input_a),
    .din_input(din_input_a), .qout_input(qin_a),
    .ce_weight(ce_weight_a), .we_weight(we_weight_a), .addr_weight(addr_weight_a),
    .din_weight(din_weight_a), .qout_weight(qw_a),
    .ce_bias(ce_bias_a), .we_bias(we_bias_a), .addr_bias(addr_bias_a),
    .din_bias(din_bias_a), .qout_bias(qb_a),
    .ce_output(ce_output_a), .we_output(we_output_a), .addr_output(addr_output_a),
    .din_output(din_output_a), .qout_output(qout_zero),
    .o_busy(o_busy_a), .layer_done(layer_done_a)
  );

  fc_layer_nlane_requant #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LANES(4), .INPUT_SIZE(8),
                           .OUTPUT_SIZE(2), .SHIFT(2), .ACC_WIDTH(32)) dut_b (
    .clk(clk), .reset(reset), .i_run(run_b),
    .ce_input(ce_input_b), .we_input(we_input_b), .addr_input(addr_input_b),
    .din_input(din_input_b), .qout_input(qin_b),
    .ce_weight(ce_weight_b), .we_weight(we_weight_b), .addr_weight(addr_weight_b),
    .din_weight(din_weight_b), .qout_weight(qw_b),
    .ce_bias(ce_bias_b), .we_bias(we_bias_b), .addr_bias(addr_bias_b),
    .din_bias(din_bias_b), .qout_bias(qb_b),
    .ce_output(ce_output_b), .we_output(we_output_b), .addr_output(addr_output_b),
    .din_output(din_output_b), .qout_output(qout_zero),
    .o_busy(o_busy_b), .layer_done(layer_done_b)
  );

  // BRAM read ports with one cycle of latency.
  always @(posedge clk) begin
    if (ce_input_a)  qin_a <= act_mem[addr_input_a[0]];
    if (ce_weight_a) qw_a  <= wt_mem[addr_weight_a[1:0]];
    if (ce_bias_a)   qb_a  <= bias_mem[addr_bias_a[0]];
    if (ce_input_b)  qin_b <= act_mem[addr_input_b[0]];
    if (ce_weight_b) qw_b  <= wt_mem[addr_weight_b[1:0]];
    if (ce_bias_b)   qb_b  <= bias_mem[addr_bias_b[0]];
  end

  int            wr_cnt_a = 0, wr_cnt_b = 0, done_cnt_a = 0, done_cnt_b = 0;
  logic [DW-1:0] log_data_a [64];
  logic [DW-1:0] log_data_b [64];
  logic [AW-1:0] log_addr_a [64];
  logic [AW-1:0] log_addr_b [64];

  // Result BRAM write log and completion-pulse counters.
  always @(posedge clk) begin
    if (ce_output_a && we_output_a) begin
      log_data_a[wr_cnt_a % 64] <= din_output_a;
      log_addr_a[wr_cnt_a % 64] <= addr_output_a;
      wr_cnt_a <= wr_cnt_a + 1;
    end
    if (ce_output_b && we_output_b) begin
      log_data_b[wr_cnt_b % 64] <= din_output_b;
      log_addr_b[wr_cnt_b % 64] <= addr_output_b;
      wr_cnt_b <= wr_cnt_b + 1;
    end
    if (layer_done_a) done_cnt_a <= done_cnt_a + 1;
    if (layer_done_b) done_cnt_b <= done_cnt_b + 1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load_mem(input logic [31:0] a0, input logic [31:0] a1,
                          input logic [31:0] w0, input logic [31:0] w1,
                          input logic [31:0] w2, input logic [31:0] w3,
                          input logic [31:0] b0, input logic [31:0] b1);
    act_mem[0] = a0; act_mem[1] = a1;
    wt_mem[0] = w0; wt_mem[1] = w1; wt_mem[2] = w2; wt_mem[3] = w3;
    bias_mem[0] = b0; bias_mem[1] = b1;
  endtask

  // Runs one layer on instance a or b and checks timing, writes and results.
  task automatic run_layer(input bit use_b, input string tag,
                           input logic [31:0] exp0, input logic [31:0] exp1);
    int   base, dbase, cyc;
    logic done_s;
    base  = use_b ? wr_cnt_b : wr_cnt_a;
    dbase = use_b ? done_cnt_b : done_cnt_a;
    @(negedge clk);
    if (use_b) run_b = 1'b1; else run_a = 1'b1;
    @(negedge clk);
    run_a = 1'b0; run_b = 1'b0;
    cyc = 1;
    check_val({tag, "_busy"}, 32'(use_b ? o_busy_b : o_busy_a), 32'd1);
    done_s = use_b ? layer_done_b : layer_done_a;
    while (!done_s && cyc < 60) begin
      @(negedge clk);
      cyc++;
      done_s = use_b ? layer_done_b : layer_done_a;
    end
    check_val({tag, "_done_cycle"}, 32'(cyc), 32'd11);
    @(negedge clk);
    check_val({tag, "_done_pulse"}, 32'(use_b ? layer_done_b : layer_done_a), 32'd0);
    check_val({tag, "_idle_busy"}, 32'(use_b ? o_busy_b : o_busy_a), 32'd0);
    check_val({tag, "_writes"}, 32'((use_b ? wr_cnt_b : wr_cnt_a) - base), 32'd2);
    check_val({tag, "_dones"}, 32'((use_b ? done_cnt_b : done_cnt_a) - dbase), 32'd1);
    check_val({tag, "_addr0"}, 32'(use_b ? log_addr_b[base % 64] : log_addr_a[base % 64]), 32'd0);
    check_val({tag, "_addr1"}, 32'(use_b ? log_addr_b[(base + 1) % 64] : log_addr_a[(base + 1) % 64]), 32'd1);
    check_val({tag, "_out0"}, use_b ? log_data_b[base % 64] : log_data_a[base % 64], exp0);
    check_val({tag, "_out1"}, use_b ? log_data_b[(base + 1) % 64] : log_data_a[(base + 1) % 64], exp1);
  endtask

  logic [31:0] neg_exp;
  logic [31:0] lane_exp1;
  int          base_w, base_d, cyc_r;

  initial begin
    reset = 1'b1;
    run_a = 1'b0;
    run_b = 1'b0;
    qin_a = '0; qw_a = '0; qb_a = '0; qin_b = '0; qw_b = '0; qb_b = '0;
    load_mem(32'h01010101, 32'h01010101, 32'h01010101, 32'h01010101,
             32'h01010101, 32'h01010101, 32'h00000000, 32'h00000000);
`ifdef FC_LAYER_RELU_EN
    neg_exp   = 32'h00000000;
    lane_exp1 = 32'h00000000;
`else
    neg_exp   = 32'hFFFFFFB0;
    lane_exp1 = 32'hFFFFFF80;
`endif
    repeat (2) @(negedge clk);
    check_val("rst_ce_input", 32'(ce_input_a), 32'd0);
    check_val("rst_ce_output", 32'(ce_output_a), 32'd0);
    check_val("rst_busy", 32'(o_busy_a), 32'd0);
    check_val("rst_done", 32'(layer_done_a), 32'd0);
    check_val("rst_addr_weight", 32'(addr_weight_a), 32'd0);
    check_val("tie_we_output", 32'(we_output_a), 32'd1);
    check_val("tie_we_input", 32'(we_input_a), 32'd0);
    check_val("tie_din_weight", din_weight_a, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // All ones: each word sums to 4, two words give 8.
    run_layer(1'b0, "ones", 32'h00000008, 32'h00000008);

    // Upper clamp: 255*127*8 saturates to 127; also proves activations are unsigned.
    load_mem(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h7F7F7F7F, 32'h7F7F7F7F,
             32'h7F7F7F7F, 32'h7F7F7F7F, 32'h00000000, 32'h00000000);
    run_layer(1'b0, "sat_hi", 32'h0000007F, 32'h0000007F);

    // Negative result: 10*(-1)*8 = -80, or 0 with ReLU.
    load_mem(32'h0A0A0A0A, 32'h0A0A0A0A, 32'hFFFFFFFF, 32'hFFFFFFFF,
             32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000000);
    run_layer(1'b0, "neg", neg_exp, neg_exp);

    // Lane order and bias: n0 = (1-2) + (7+16) = 22; n1 = 2 - 200 clamps low.
    load_mem(32'h01020304, 32'h05060708, 32'h01FF0000, 32'h00000102,
             32'h02000000, 32'h00000000, 32'h00000000, 32'hFFFFFF38);
    run_layer(1'b0, "lanes", 32'h00000016, lane_exp1);

    // SHIFT=2 instance: (8 + 3) >>> 2 = 2.
    load_mem(32'h01010101, 32'h01010101, 32'h01010101, 32'h01010101,
             32'h01010101, 32'h01010101, 32'h00000003, 32'h00000003);
    run_layer(1'b1, "shift2", 32'h00000002, 32'h00000002);

    // Reset in cycle 3 of a run aborts it without writing.
    load_mem(32'h01020304, 32'h05060708, 32'h01FF0000, 32'h00000102,
             32'h02000000, 32'h00000000, 32'h00000000, 32'hFFFFFF38);
    base_w = wr_cnt_a;
    base_d = done_cnt_a;
    @(negedge clk); run_a = 1'b1;
    @(negedge clk); run_a = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check_val("abort_busy", 32'(o_busy_a), 32'd0);
    check_val("abort_ce", 32'({ce_input_a, ce_weight_a, ce_bias_a, ce_output_a}), 32'd0);
    check_val("abort_addr", 32'({addr_input_a, addr_weight_a, addr_bias_a, addr_output_a} != '0), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check_val("abort_no_write", 32'(wr_cnt_a - base_w), 32'd0);
    check_val("abort_no_done", 32'(done_cnt_a - base_d), 32'd0);
    run_layer(1'b0, "rerun", 32'h00000016, lane_exp1);

    // A second i_run during LOAD is ignored.
    load_mem(32'h01010101, 32'h01010101, 32'h01010101, 32'h01010101,
             32'h01010101, 32'h01010101, 32'h00000000, 32'h00000000);
    base_w = wr_cnt_a;
    base_d = done_cnt_a;
    @(negedge clk); run_a = 1'b1;
    @(negedge clk); run_a = 1'b1;
    @(negedge clk); run_a = 1'b0;
    cyc_r = 2;
    while (!layer_done_a && cyc_r < 60) begin
      @(negedge clk);
      cyc_r++;
    end
    check_val("repulse_done_cycle", 32'(cyc_r), 32'd11);
    repeat (20) @(negedge clk);
    check_val("repulse_writes", 32'(wr_cnt_a - base_w), 32'd2);
    check_val("repulse_dones", 32'(done_cnt_a - base_d), 32'd1);
    check_val("repulse_out0", log_data_a[base_w % 64], 32'h00000008);
    check_val("repulse_out1", log_data_a[(base_w + 1) % 64], 32'h00000008);
    check_val("repulse_busy", 32'(o_busy_a), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
